digit_scan_mux: RTL and testbench

// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/digit_scan_mux_pkg.sv | 20 ++
 rtl/digit_scan_mux_lz_blank.sv | 28 ++
 rtl/digit_scan_mux.sv | 172 +++++++++++++++++
 tb/tb_digit_scan_mux.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/digit_scan_mux_pkg.sv
// Shared definitions for the digit scan multiplexer.
// Contents: nibble width, the two-state scan FSM encoding and a helper that sizes
// the phase counter so it can hold the longer of the SHOW and GUARD intervals.
package digit_scan_mux_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic {
        StGuard = 1'b0,
        StShow  = 1'b1
    } scan_state_e;

    // Width of a counter that must reach max(a, b).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/digit_scan_mux_lz_blank.sv
// Leading-zero blank mask (combinational).
// Ports:
//   value  in   DIGIT_W*N_DIGITS  packed hex value, nibble 0 least significant
//   mask   out  N_DIGITS          1 = digit is a leading zero and should be blanked
// Digit 0 is never blanked so a value of zero still shows a single "0".
module lz_blank_mask
    import digit_scan_mux_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4
) (
    input  logic [DIGIT_W*N_DIGITS-1:0] value,
    output logic [N_DIGITS-1:0]         mask
);

    logic higher_zero;

    always_comb begin
        mask        = '0;
        higher_zero = 1'b1;
        // Walk from the most significant digit down; a digit is blanked while every
        // nibble from it upward is zero.
        for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
            higher_zero = higher_zero & (value[DIGIT_W*k +: DIGIT_W] == '0);
            mask[k]     = (k != 0) && higher_zero;
        end
    end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Walks the digits one at a time with an all-off guard interval between them, and
// per digit presents the nibble to decode, a blank flag and a digit-select strobe.
// A shadow register takes new data at any time; it is copied to the displayed value
// only at the frame boundary so a frame never mixes old and new digits.
// Ports:
//   clk         in   1                 system clock, rising edge
//   rst_n       in   1                 synchronous reset, active-low
//   data_in     in   4*N_DIGITS        packed value, nibble k = data_in[4k+3:4k]
//   load        in   1                 strobe: capture data_in into the shadow register
//   lz_en       in   1                 1 = leading-zero suppression
//   nibble      out  4                 value for the segment decoder
//   blank       out  1                 1 = force all segments off
//   dig_sel     out  N_DIGITS          one-hot digit enable, polarity from DIG_ACT_LOW
//   pending     out  1                 shadow holds data not yet shown
//   frame_done  out  1                 1-cycle pulse after the last digit's SHOW ends
// All outputs are registered; they are computed from next-state values so they line
// up with the FSM state they describe.
module digit_scan_mux
    import digit_scan_mux_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned GUARD_CYC   = 8,
    parameter int unsigned DIG_ACT_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIGIT_W*N_DIGITS-1:0] data_in,
    input  logic                        load,
    input  logic                        lz_en,
    output logic [DIGIT_W-1:0]          nibble,
    output logic                        blank,
    output logic [N_DIGITS-1:0]         dig_sel,
    output logic                        pending,
    output logic                        frame_done
);

    localparam int unsigned CNT_W = cnt_width(SCAN_DIV, GUARD_CYC);
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned VAL_W = DIGIT_W * N_DIGITS;

    localparam logic [CNT_W-1:0]    SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    GUARD_LAST = (GUARD_CYC == 0) ? '0 : CNT_W'(GUARD_CYC - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] DIG_OFF    = (DIG_ACT_LOW != 0) ? '1 : '0;

    scan_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [VAL_W-1:0]     active_q, active_d;
    logic [VAL_W-1:0]     shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 frame_done_q;
    logic                 wrap;

    logic [DIGIT_W-1:0]   nibble_q, nibble_d;
    logic                 blank_q, blank_d;
    logic [N_DIGITS-1:0]  dig_sel_q, dig_sel_d;
    logic [N_DIGITS-1:0]  lz_mask;

    // Scan FSM: next state, digit index and phase counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        wrap    = 1'b0;
        unique case (state_q)
            StGuard: begin
                if (GUARD_CYC == 0 || cnt_q == GUARD_LAST) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
            end
            StShow: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    // With no guard interval the next digit's SHOW follows directly.
                    if (GUARD_CYC != 0) begin
                        state_d = StGuard;
                    end
                end
            end
            default: begin
                state_d = StGuard;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow/active double buffer: active only changes on the wrap cycle.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        active_d  = active_q;
        if (load) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end
        if (wrap) begin
            if (load) begin
                active_d  = data_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end
    end

    lz_blank_mask #(
        .N_DIGITS (N_DIGITS)
    ) u_lz_blank_mask (
        .value (active_d),
        .mask  (lz_mask)
    );

    // Output decode from next-state values, registered below.
    always_comb begin
        nibble_d  = '0;
        blank_d   = 1'b1;
        dig_sel_d = DIG_OFF;
        if (state_d == StShow) begin
            for (int k = 0; k < int'(N_DIGITS); k++) begin
                if (idx_d == IDX_W'(k)) begin
                    nibble_d     = active_d[DIGIT_W*k +: DIGIT_W];
                    blank_d      = lz_en & lz_mask[k];
                    dig_sel_d[k] = ~DIG_OFF[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StGuard;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            nibble_q     <= '0;
            blank_q      <= 1'b1;
            dig_sel_q    <= DIG_OFF;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= wrap;
            nibble_q     <= nibble_d;
            blank_q      <= blank_d;
            dig_sel_q    <= dig_sel_d;
        end
    end

    assign nibble     = nibble_q;
    assign blank      = blank_q;
    assign dig_sel    = dig_sel_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Directed bench for digit_scan_mux with N_DIGITS=4, SCAN_DIV=4, GUARD_CYC=1,
// active-low digit selects. A frame is 20 cycles: frame cycle 0 is the guard that
// follows the wrap, then per digit d four SHOW cycles and (except after digit 3)
// one guard cycle.
module tb_digit_scan_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  nibble;
    logic        blank;
    logic [3:0]  dig_sel;
    logic        pending;
    logic        frame_done;

    int n_chk;
    int n_fail;

    digit_scan_mux #(
        .N_DIGITS    (4),
        .SCAN_DIV    (4),
        .GUARD_CYC   (1),
        .DIG_ACT_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .load       (load),
        .lz_en      (lz_en),
        .nibble     (nibble),
        .blank      (blank),
        .dig_sel    (dig_sel),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Run nf cycles of a frame starting at frame cycle 0, checking every cycle.
    // val/bexp: displayed value and per-digit blank; fd0: frame_done expected at cycle 0.
    // la/lb: frame cycles on which load is driven (-1 = none) with data lva/lvb.
    task automatic run_frame(input string tag, input logic [15:0] val, input logic [3:0] bexp,
                             input logic fd0, input int la, input logic [15:0] lva,
                             input int lb, input logic [15:0] lvb, input int nf);
        for (int f = 0; f < nf; f++) begin
            int   g;
            int   r;
            logic pexp;
            g    = (f - 1) / 5;
            r    = (f - 1) % 5;
            pexp = (la >= 0 && la < f) || (lb >= 0 && lb < f);
            if (f == 0 || r == 4) begin
                chk($sformatf("%s f%0d guard dig_sel", tag, f), dig_sel, 4'b1111);
                chk($sformatf("%s f%0d guard blank", tag, f), blank, 1'b1);
            end else begin
                logic [3:0] sel;
                logic [3:0] nib;
                sel = ~(4'b0001 << g);
                nib = val[4*g +: 4];
                chk($sformatf("%s f%0d dig_sel", tag, f), dig_sel, sel);
                chk($sformatf("%s f%0d nibble", tag, f), nibble, nib);
                chk($sformatf("%s f%0d blank", tag, f), blank, bexp[g]);
            end
            chk($sformatf("%s f%0d frame_done", tag, f), frame_done, (f == 0) ? fd0 : 1'b0);
            chk($sformatf("%s f%0d pending", tag, f), pending, pexp);
            load = 1'b0;
            if (f == la) begin
                load    = 1'b1;
                data_in = lva;
            end
            if (f == lb) begin
                load    = 1'b1;
                data_in = lvb;
            end
            cyc();
            load = 1'b0;
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        load    = 1'($urandom);
        data_in = 16'($urandom);
        lz_en   = 1'($urandom);

        // 1) reset held for two cycles
        cyc();
        cyc();
        chk("reset dig_sel", dig_sel, 4'b1111);
        chk("reset blank", blank, 1'b1);
        chk("reset nibble", nibble, 4'h0);
        chk("reset pending", pending, 1'b0);
        chk("reset frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        load  = 1'b0;
        lz_en = 1'b0;

        // 2) load 1234; current frame still shows zero, next frame shows 1234
        run_frame("f0", 16'h0000, 4'b0000, 1'b0, 0, 16'h1234, -1, 16'h0, 20);
        run_frame("f1234", 16'h1234, 4'b0000, 1'b1, 5, 16'h0050, -1, 16'h0, 20);

        // 3) leading-zero suppression on 0050, then 0000
        lz_en = 1'b1;
        run_frame("lz0050", 16'h0050, 4'b1100, 1'b1, 7, 16'h0000, -1, 16'h0, 20);

        // 4) two loads mid-frame: frame unchanged, last load wins
        run_frame("lz0000", 16'h0000, 4'b1110, 1'b1, 3, 16'hABCD, 12, 16'hBEEF, 20);
        lz_en = 1'b0;

        // 5) load on the wrap cycle goes straight to active
        run_frame("fBEEF", 16'hBEEF, 4'b0000, 1'b1, 19, 16'h9876, -1, 16'h0, 20);

        // 6) reset mid-SHOW of digit 2 with a load that must be discarded
        run_frame("f9876", 16'h9876, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0, 12);
        chk("mid d2 dig_sel", dig_sel, 4'b1011);
        chk("mid d2 nibble", nibble, 4'h8);
        rst_n   = 1'b0;
        load    = 1'b1;
        data_in = 16'h5555;
        cyc();
        rst_n = 1'b1;
        load  = 1'b0;
        chk("rst2 dig_sel", dig_sel, 4'b1111);
        chk("rst2 blank", blank, 1'b1);
        chk("rst2 nibble", nibble, 4'h0);
        chk("rst2 pending", pending, 1'b0);
        chk("rst2 frame_done", frame_done, 1'b0);
        run_frame("post_rst_a", 16'h0000, 4'b0000, 1'b0, -1, 16'h0, -1, 16'h0, 20);
        run_frame("post_rst_b", 16'h0000, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
